// File: rtl/arbitro_rr4_if.sv
// Request/grant bundle between the requesters, the arbiter and the mux consumer.
// master = arbiter side, slave = requester/consumer side.
interface arbitro_rr4_if;
    logic [3:0] REQ;
    logic       ACK;
    logic [1:0] SEL;
    logic       VALID;
    logic [3:0] GNT;
    logic       ERRO;

    modport master (
        input  REQ,
        input  ACK,
        output SEL,
        output VALID,
        output GNT,
        output ERRO
    );

    modport slave (
        output REQ,
        output ACK,
        input  SEL,
        input  VALID,
        input  GNT,
        input  ERRO
    );
endinterface

// File: rtl/arbitro_rr4.sv
// Four-way round-robin arbiter driving the SEL of a 4:1 mux.
// Optional grant timeout built when ARB_TIMEOUT_EN is defined.
module arbitro_rr4 #(
    parameter int p_SEL  = 2,
    parameter int p_TMAX = 15
) (
    input  logic          CLK,
    input  logic          RST,
    arbitro_rr4_if.master bus
);

    if (p_SEL != 2 || p_TMAX < 1 || p_TMAX > 255) begin : g_bad_param
        $error("arbitro_rr4: illegal p_SEL or p_TMAX");
    end

    typedef enum logic {LIVRE, CONCEDE} estado_t;

    estado_t          estado, estado_n;
    logic [p_SEL-1:0] sel_q, sel_n;
    logic [p_SEL-1:0] ultimo, ultimo_n;
    logic [3:0]       gnt_q, gnt_n;
    logic             valid_q, valid_n;
    logic             erro_q, erro_n;
    logic [3:0]       pend;
    logic [1:0]       venc;
    logic             tout;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] LIM = 8'(p_TMAX - 1);
    logic [7:0] cnt, cnt_n;
`endif

    // First pending index after u, wrapping; u itself is checked last.
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] u
    );
        logic [1:0] w;
        logic [1:0] c;
        w = u;
        for (int k = 4; k >= 1; k--) begin
            c = u + 2'(k);
            if (r[c]) w = c;
        end
        return w;
    endfunction

    always_comb begin
        estado_n = estado;
        sel_n    = sel_q;
        gnt_n    = gnt_q;
        valid_n  = valid_q;
        erro_n   = 1'b0;
        ultimo_n = ultimo;
`ifdef ARB_TIMEOUT_EN
        cnt_n    = cnt;
        tout     = (cnt == LIM);
`else
        tout     = 1'b0;
`endif
        // The live requester is masked so an ACK always moves on.
        pend = (estado == CONCEDE) ? (bus.REQ & ~gnt_q) : bus.REQ;
        venc = pick(pend, ultimo);

        unique case (estado)
            LIVRE: begin
                if (|bus.REQ) begin
                    estado_n = CONCEDE;
                    sel_n    = venc;
                    gnt_n    = 4'(1) << venc;
                    valid_n  = 1'b1;
                    ultimo_n = venc;
`ifdef ARB_TIMEOUT_EN
                    cnt_n    = 8'd0;
`endif
                end
            end
            CONCEDE: begin
                if (bus.ACK) begin
                    if (|pend) begin
                        sel_n    = venc;
                        gnt_n    = 4'(1) << venc;
                        ultimo_n = venc;
`ifdef ARB_TIMEOUT_EN
                        cnt_n    = 8'd0;
`endif
                    end else begin
                        estado_n = LIVRE;
                        valid_n  = 1'b0;
                        gnt_n    = 4'd0;
                    end
                end else if (!bus.REQ[sel_q] || tout) begin
                    estado_n = LIVRE;
                    valid_n  = 1'b0;
                    gnt_n    = 4'd0;
                    erro_n   = 1'b1;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
`endif
                end
            end
            default: estado_n = LIVRE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado  <= LIVRE;
            sel_q   <= '0;
            gnt_q   <= 4'd0;
            valid_q <= 1'b0;
            erro_q  <= 1'b0;
            ultimo  <= 2'd3;
        end else begin
            estado  <= estado_n;
            sel_q   <= sel_n;
            gnt_q   <= gnt_n;
            valid_q <= valid_n;
            erro_q  <= erro_n;
            ultimo  <= ultimo_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt <= 8'd0;
        else     cnt <= cnt_n;
    end
`endif

    assign bus.SEL   = sel_q;
    assign bus.GNT   = gnt_q;
    assign bus.VALID = valid_q;
    assign bus.ERRO  = erro_q;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Directed scoreboard bench for arbitro_rr4 (p_TMAX=4).
// Timeout steps follow ARB_TIMEOUT_EN; the default build checks hold-forever.
module tb_arbitro_rr4;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] gnt;
        logic       erro;
    } exp_t;

    exp_t q[$];

    arbitro_rr4_if bus();

    arbitro_rr4 #(
        .p_SEL (2),
        .p_TMAX(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach summary");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [1:0] s,
                        input logic v, input logic [3:0] g,
                        input logic e);
        exp_t x;
        x.tag   = tag;
        x.sel   = s;
        x.valid = v;
        x.gnt   = g;
        x.erro  = e;
        q.push_back(x);
    endtask

    task automatic chk();
        exp_t x;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: queue empty, got sel=%0d valid=%0b",
                   bus.SEL, bus.VALID);
            return;
        end
        x = q.pop_front();
        assert ({bus.SEL, bus.VALID, bus.GNT, bus.ERRO} ===
                {x.sel, x.valid, x.gnt, x.erro})
        else begin
            errors++;
            $error("FAIL %s: got sel=%0d valid=%0b gnt=%b erro=%0b, want sel=%0d valid=%0b gnt=%b erro=%0b",
                   x.tag, bus.SEL, bus.VALID, bus.GNT, bus.ERRO,
                   x.sel, x.valid, x.gnt, x.erro);
        end
    endtask

    // Drive, expect outputs after the next edge, then sample.
    task automatic cyc(input string tag, input logic [3:0] r,
                       input logic a, input logic [1:0] s,
                       input logic v, input logic [3:0] g,
                       input logic e);
        bus.REQ = r;
        bus.ACK = a;
        push(tag, s, v, g, e);
        @(posedge CLK);
        #1;
        chk();
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        bus.REQ = 4'd0;
        bus.ACK = 1'b0;
        push("reset", 2'd0, 1'b0, 4'd0, 1'b0);
        @(posedge CLK);
        #1;
        chk();
        RST = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        RST     = 1'b1;
        bus.REQ = 4'd0;
        bus.ACK = 1'b0;
        @(posedge CLK);
        do_reset();

        cyc("single_gnt",  4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0);
        cyc("single_ack",  4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0);
        cyc("single_idle", 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);

        do_reset();
        cyc("fair0",     4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0);
        cyc("fair1",     4'b1111, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0);
        cyc("fair2",     4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0);
        cyc("fair3",     4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0);
        cyc("fair4",     4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0);
        cyc("fair_done", 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0);

        cyc("last3_gnt", 4'b1000, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0);
        cyc("last3_ack", 4'b1000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0);
        cyc("wrap_skip", 4'b1010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0);
        cyc("b2b_next",  4'b1010, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0);
        cyc("b2b_done",  4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0);

        cyc("ab_gnt",    4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0);
        cyc("abort",     4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b1);
        cyc("abort_end", 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);
        cyc("ab2_gnt",   4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0);
        cyc("ack_wins",  4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
        cyc("to_gnt",    4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("to_hold", 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0);
        cyc("to_fire",   4'b0001, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
        cyc("to_next",   4'b0011, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0);
        cyc("to_ack",    4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0);
`else
        cyc("hold_gnt",  4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0);
        for (int i = 0; i < 100; i++)
            cyc("hold", 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0);
        cyc("hold_ack",  4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0);
`endif

        cyc("rst_gnt",   4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        push("async_rst", 2'd0, 1'b0, 4'd0, 1'b0);
        chk();
        bus.REQ = 4'b1111;
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        push("post_rst", 2'd0, 1'b1, 4'b0001, 1'b0);
        chk();
        cyc("post_rst2", 4'b1111, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0);

        checks++;
        assert (q.size() == 0)
        else begin
            errors++;
            $error("FAIL queue_drain: got %0d left, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_rr4.md
# arbitro_rr4

Four-requester round-robin arbiter that drives the 2-bit `SEL` of the downstream 4:1 four-bit data mux. It picks one pending requester per transaction, holds `SEL` stable while `VALID` is high, and releases on consumer `ACK`. An optional timeout drops grants that the consumer never acknowledges, so one stuck requester cannot stall the mux.

## Interface
- `p_SEL`, 2: width of `SEL`. Fixed; do not override.
- `p_TMAX`, 15: grant timeout in cycles. Legal range 1..255.
- `CLK  input  1`: rising-edge clock.
- `RST  input  1`: asynchronous, active-high reset.
- `REQ  input  4`: request per mux input; bit i requests `ENTi`. Level-sensitive.
- `ACK  input  1`: consumer accepted the current selection. Only meaningful while `VALID`=1.
- `SEL  output  2`: index of the granted requester. Connects to mux `SEL`.
- `VALID  output  1`: `SEL` holds a live grant.
- `GNT  output  4`: one-hot grant, equal to `1 << SEL` when `VALID`=1, else 0.
- `ERRO  output  1`: one-cycle pulse on timeout or aborted grant.

## Operation
- All outputs are registered. Reset values: `SEL`=0, `VALID`=0, `GNT`=0, `ERRO`=0. Internal state after reset: state `LIVRE`, `ultimo`=3, counter=0.
- `ultimo` (2 bits) holds the last granted index. Priority order is `ultimo+1`, `ultimo+2`, `ultimo+3`, `ultimo`, all mod 4, with wrap-around 3→0.
- **State `LIVRE`:** `VALID`=0.
  - If `REQ`≠0 at the edge: pick the winner and go to `CONCEDE`.
  - At that same edge: `SEL`←winner, `GNT`←one-hot winner, `VALID`←1, `ultimo`←winner, counter←0.
- **State `CONCEDE`:** `SEL` and `GNT` stay frozen while in this state.
  - ACK (`ACK`=1 at the edge):
    - If `REQ` with the current bit masked is ≠0, re-arbitrate in the same edge. Stay in `CONCEDE` with the new `SEL`; `VALID` stays 1 (back-to-back, no bubble).
    - Otherwise go to `LIVRE`, `VALID`←0, `GNT`←0. `SEL` keeps its last value.
    - The current requester is never re-granted on the ACK edge, even if it is the only one still requesting.
  - Abort (`ACK`=0 and `REQ[SEL]`=0 at the edge): go to `LIVRE`, `VALID`←0, `ERRO`←1 for one cycle.
  - Timeout (`ARB_TIMEOUT_EN` only): `ACK`=0 and counter=`p_TMAX`-1 at the edge.
    - Go to `LIVRE`, `VALID`←0, `ERRO`←1 for one cycle.
    - `ultimo` is unchanged, so the next grant goes to a different pending requester when one exists.
  - Otherwise: counter increments. It saturates at 255 and is 8 bits wide.
- Simultaneous events at one edge:
  - ACK wins over abort and over timeout; no `ERRO` is raised.
  - Abort and timeout together raise a single `ERRO` pulse.
- Reset asserted mid-grant forces the reset values immediately, without waiting for a clock edge. `ERRO` is not raised.

## Timing
- Request-to-grant latency is 1 cycle: `REQ` sampled at edge N gives `VALID`/`SEL` valid after edge N.
- `SEL` is stable for the whole time `VALID`=1 within one grant. The mux output `saida` is valid in the same cycles.
- `ACK` sampled at edge N: the new `SEL` (back-to-back case) or `VALID`=0 appears after edge N.
- Timeout: with no `ACK`, `VALID` is high for exactly `p_TMAX` cycles. `ERRO` is high in the cycle right after `VALID` falls.
- Throughput: one grant per cycle when `ACK` is held at 1 and several requesters are pending.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined: the counter and timeout path are built as described above.
- Undefined:
  - No counter is built, and the grant is held indefinitely until ACK or abort.
  - `ERRO` pulses only on abort.
  - `p_TMAX` is ignored.

## Test plan
- **Reset, then single request:** `REQ`=4'b0100 → after 1 edge `SEL`=2, `GNT`=4'b0100, `VALID`=1. With `ACK`=1 for 1 cycle → `VALID`=0, `SEL` stays 2.
- **Fairness:** `REQ`=4'b1111 held, `ACK`=1 held from reset → `SEL` sequence 0,1,2,3,0 on consecutive cycles, `VALID` continuously 1.
- **Wrap and skip:** last grant 3, then `REQ`=4'b1010 → `SEL`=1. After ACK, `REQ`=4'b1010 still held → `SEL`=3.
- **Timeout** (`ARB_TIMEOUT_EN`, `p_TMAX`=4): `REQ`=4'b0001, `ACK`=0 → `VALID` high for exactly 4 cycles, then `ERRO` pulses for 1 cycle. With `REQ`=4'b0011 instead, the next grant is `SEL`=1. Without the macro, `VALID` is still high at cycle 100.
- **Abort:** granted `SEL`=2, then `REQ[2]` dropped with `ACK`=0 → next edge `VALID`=0, `ERRO`=1 for 1 cycle. Same edge with `ACK`=1 → no `ERRO`.
- **Async reset mid-grant:** assert `RST` between edges while `VALID`=1 → `VALID`, `GNT`, `SEL`, `ERRO` go to 0 before the next `CLK` edge. After release with `REQ`=4'b1111, the first grant is `SEL`=0.
